// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-port CPU register file.
//
// Contents:
//   XLEN_DEF, NREG_DEF  default data width / register count
//   ZERO_ADDR           address of the hard-wired zero register
//   reg_addr_t, word_t  address / data types for the default configuration
//   merge_byte()        picks one byte out of several same-cycle writers,
//                       highest-index writer wins
//   addr_valid()        true when an address names a real, writable register
//
// merge_byte() is used by both the storage update and the read bypass, so
// the committed value and the bypassed value can never disagree.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int          XLEN_DEF  = 32;
    localparam int          NREG_DEF  = 32;
    localparam int          AW_DEF    = $clog2(NREG_DEF);
    localparam int unsigned ZERO_ADDR = 0;

    // Fixed upper bound on the write ports the merge can arbitrate between.
    // Callers zero-pad their lanes/hits up to this size.
    localparam int NWR_MAX = 16;
    localparam int LANES_W = NWR_MAX * 8;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] word_t;
    typedef logic [7:0]          byte_t;

    // Walks the writers from lowest to highest index so that the last
    // writer with its hit set (the highest index) overrides the others.
    // With no hits the old byte is returned unchanged.
    function automatic byte_t merge_byte(
        input byte_t                old_byte,
        input logic [LANES_W-1:0]   lanes,
        input logic [NWR_MAX-1:0]   hits
    );
        byte_t result;
        result = old_byte;
        for (int i = 0; i < NWR_MAX; i++) begin
            if (hits[i]) begin
                result = lanes[i*8 +: 8];
            end
        end
        return result;
    endfunction

    // An address is usable when it falls inside the register array and,
    // when the zero register is enabled, is not the zero register.
    function automatic logic addr_valid(
        input int unsigned addr,
        input int unsigned nreg,
        input int          zero_reg
    );
        logic valid;
        valid = (addr < nreg);
        if (zero_reg != 0 && addr == ZERO_ADDR) begin
            valid = 1'b0;
        end
        return valid;
    endfunction

endpackage

// File: rtl/cpu_regfile_sb.sv
// ---------------------------------------------------------------------------
// cpu_regfile_sb
// Per-register busy scoreboard for hazard detection.
//
// A register becomes busy when decode reserves it (rsv_en/rsv_addr) and
// stops being busy when writeback writes it. A reservation and a write to
// the same register in one cycle leave it busy: the reservation belongs to
// a newer producer than the write that is retiring.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   raddr      NRD packed read addresses
//   rbusy      NRD busy flags for the addressed registers
//   we, waddr  NWR write enables / addresses (data is irrelevant here)
//   rsv_en     reserve request
//   rsv_addr   register to reserve
// ---------------------------------------------------------------------------
module cpu_regfile_sb
    import cpu_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD-1:0]    rbusy,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;
    logic [AW-1:0]   look_addr;
    logic            look_wr_hit;

    // Every enabled write clears the busy bit of its target, whether or not
    // any byte strobe is set. Out-of-range targets are simply dropped.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NWR; i++) begin
            if (we[i] && addr_valid(32'(waddr[i*AW +: AW]), NREG, 0)) begin
                clr_vec[waddr[i*AW +: AW]] = 1'b1;
            end
        end
    end

    // Reservations to the zero register or past the end of the array are
    // ignored, so those bits can never become busy.
    always_comb begin
        set_vec = '0;
        if (rsv_en && addr_valid(32'(rsv_addr), NREG, ZERO_REG)) begin
            set_vec[rsv_addr] = 1'b1;
        end
    end

    // Set has priority over clear so a same-cycle reserve survives the write.
    always_comb begin
        busy_next = set_vec | (busy & ~clr_vec);
    end

    // Busy vector register; cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Lookup per read port. With bypass the flag drops in the very cycle the
    // producer writes back, because the read port already sees the new data.
    // A same-cycle reservation is never visible here.
    always_comb begin
        rbusy       = '0;
        look_addr   = '0;
        look_wr_hit = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            look_addr   = raddr[k*AW +: AW];
            look_wr_hit = 1'b0;
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && waddr[i*AW +: AW] == look_addr) begin
                    look_wr_hit = 1'b1;
                end
            end
            if (!rst && addr_valid(32'(look_addr), NREG, ZERO_REG)) begin
                rbusy[k] = busy[look_addr] && !(BYPASS != 0 && look_wr_hit);
            end
        end
    end

endmodule

// File: rtl/cpu_regfile_mp.sv
// ---------------------------------------------------------------------------
// cpu_regfile_mp
// Parametrised multi-port CPU register file with byte-enable writes, an
// optional hard-wired zero register, optional write-to-read bypass and a
// busy scoreboard (cpu_regfile_sb) for hazard detection.
//
// Ports:
//   clk, rst   clock (rising edge) and asynchronous active-high reset
//   raddr      NRD packed read addresses, port k at [k*AW +: AW]
//   rdata      NRD packed read data, combinational from raddr
//   rbusy      NRD busy flags for the addressed registers
//   we         NWR write enables, higher index = higher priority
//   waddr      NWR packed write addresses
//   wdata      NWR packed write data
//   wstrb      NWR packed byte strobes, XLEN/8 per port
//   rsv_en     reserve request for rsv_addr
//   rsv_addr   register to mark busy
//
// Reads of the zero register, of addresses past the end of the array, and
// any read while rst is high return 0, so unused ports never carry X.
// ---------------------------------------------------------------------------
module cpu_regfile_mp
    import cpu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*XLEN-1:0]   rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AW-1:0]     waddr,
    input  logic [NWR*XLEN-1:0]   wdata,
    input  logic [NWR*XLEN/8-1:0] wstrb,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] stored [NREG];
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_word;

    // Overlays every same-cycle write aimed at 'addr' onto 'old_word', byte
    // by byte. For each byte the writers whose enable, address and strobe all
    // match are collected and merge_byte picks the highest-index one.
    // Everything the result depends on is passed in explicitly so the
    // function is safe to call from continuous assignments.
    function automatic logic [XLEN-1:0] merge_word(
        input logic [XLEN-1:0]     old_word,
        input logic [AW-1:0]       addr,
        input logic [NWR-1:0]      w_en,
        input logic [NWR*AW-1:0]   w_addr,
        input logic [NWR*XLEN-1:0] w_data,
        input logic [NWR*NB-1:0]   w_strb
    );
        logic [XLEN-1:0]    result;
        logic [NWR_MAX-1:0] hits;
        logic [LANES_W-1:0] lanes;
        result = old_word;
        for (int b = 0; b < NB; b++) begin
            hits  = '0;
            lanes = '0;
            for (int i = 0; i < NWR; i++) begin
                hits[i]         = w_en[i] && (w_addr[i*AW +: AW] == addr)
                                  && w_strb[i*NB + b];
                lanes[i*8 +: 8] = w_data[i*XLEN + b*8 +: 8];
            end
            result[b*8 +: 8] = merge_byte(old_word[b*8 +: 8], lanes, hits);
        end
        return result;
    endfunction

    // One storage word per register. The zero register, when enabled, has
    // no flop at all and is tied to 0, which is how its writes get dropped.
    // Writes to addresses past NREG match no generated register and vanish.
    for (genvar r = 0; r < NREG; r++) begin : g_reg
        if (ZERO_REG != 0 && r == ZERO_ADDR) begin : g_zero
            assign stored[r] = '0;
        end else begin : g_data
            logic [XLEN-1:0] q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= '0;
                end else begin
                    q <= merge_word(q, AW'(r), we, waddr, wdata, wstrb);
                end
            end

            assign stored[r] = q;
        end
    end

    // Combinational read ports. With bypass the same merge that feeds the
    // flops is applied to the read value, so a reader sees exactly what the
    // register will hold after this edge.
    always_comb begin
        rdata   = '0;
        rd_addr = '0;
        rd_word = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_addr = raddr[k*AW +: AW];
            rd_word = '0;
            if (!rst && addr_valid(32'(rd_addr), NREG, ZERO_REG)) begin
                rd_word = stored[rd_addr];
                if (BYPASS != 0) begin
                    rd_word = merge_word(rd_word, rd_addr, we, waddr, wdata, wstrb);
                end
            end
            rdata[k*XLEN +: XLEN] = rd_word;
        end
    end

    // Busy tracking lives in its own block; it only needs addresses and
    // enables, never data.
    cpu_regfile_sb #(
        .NREG     (NREG),
        .AW       (AW),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .raddr    (raddr),
        .rbusy    (rbusy),
        .we       (we),
        .waddr    (waddr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr)
    );

endmodule

// File: tb/tb_cpu_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_cpu_regfile_mp
// Testbench for cpu_regfile_mp. Two instances share clock and reset:
//   dut  : default build (32x32, 2 read / 2 write, zero register, bypass)
//   dut2 : XLEN=64, NREG=24, NRD=3, NWR=1, ZERO_REG=0, BYPASS=0
// dut is compared against a behavioural array model; dut2 against constants.
// ---------------------------------------------------------------------------
module tb_cpu_regfile_mp;

    logic clk;
    logic rst;

    logic [9:0]   raddr;
    logic [63:0]  rdata;
    logic [1:0]   rbusy;
    logic [1:0]   we;
    logic [9:0]   waddr;
    logic [63:0]  wdata;
    logic [7:0]   wstrb;
    logic         rsv_en;
    logic [4:0]   rsv_addr;

    logic [14:0]  raddr2;
    logic [191:0] rdata2;
    logic [2:0]   rbusy2;
    logic [0:0]   we2;
    logic [4:0]   waddr2;
    logic [63:0]  wdata2;
    logic [7:0]   wstrb2;
    logic         rsv_en2;
    logic [4:0]   rsv_addr2;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Reference state: register contents and busy flags as the
    // architecture defines them.
    logic [31:0] m_mem  [32];
    logic        m_busy [32];

    cpu_regfile_mp dut (
        .clk      (clk),
        .rst      (rst),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr)
    );

    cpu_regfile_mp #(
        .XLEN     (64),
        .NREG     (24),
        .NRD      (3),
        .NWR      (1),
        .ZERO_REG (0),
        .BYPASS   (0)
    ) dut2 (
        .clk      (clk),
        .rst      (rst),
        .raddr    (raddr2),
        .rdata    (rdata2),
        .rbusy    (rbusy2),
        .we       (we2),
        .waddr    (waddr2),
        .wdata    (wdata2),
        .wstrb    (wstrb2),
        .rsv_en   (rsv_en2),
        .rsv_addr (rsv_addr2)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, expected $finish before t=200000");
        $fatal(1, "[TB] timeout");
    end

    // One comparison: counts it, passes or reports tag/observed/expected.
    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected read value of register a for dut: stored word with this
    // cycle's writes overlaid, lower port first so port 1 wins per byte.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        logic [31:0] v;
        v = (a == 5'd0) ? 32'h0 : m_mem[a];
        if (a != 5'd0) begin
            for (int i = 0; i < 2; i++) begin
                if (we[i] && waddr[i*5 +: 5] == a) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb[i*4 + b]) v[b*8 +: 8] = wdata[i*32 + b*8 +: 8];
                    end
                end
            end
        end
        return v;
    endfunction

    // Expected busy flag for dut: reserved and not being written this cycle.
    function automatic logic exp_busy(input logic [4:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (we[i] && waddr[i*5 +: 5] == a) hit = 1'b1;
        end
        return (a != 5'd0) && m_busy[a] && !hit;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 32; a++) begin
            m_mem[a]  = 32'h0;
            m_busy[a] = 1'b0;
        end
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_commit();
        logic hit;
        for (int a = 1; a < 32; a++) begin
            hit = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (we[i] && waddr[i*5 +: 5] == 5'(a)) hit = 1'b1;
            end
            m_mem[a] = exp_read(5'(a));
            if (hit) m_busy[a] = 1'b0;
            if (rsv_en && rsv_addr == 5'(a)) m_busy[a] = 1'b1;
        end
    endtask

    // Drive all dut inputs for one cycle, then let the comb outputs settle.
    task automatic apply_stimulus(
        input logic [1:0]  en,
        input logic [4:0]  a0, input logic [31:0] d0, input logic [3:0] s0,
        input logic [4:0]  a1, input logic [31:0] d1, input logic [3:0] s1,
        input logic        rsv, input logic [4:0] ra,
        input logic [4:0]  rd0, input logic [4:0] rd1
    );
        we       = en;
        waddr    = {a1, a0};
        wdata    = {d1, d0};
        wstrb    = {s1, s0};
        rsv_en   = rsv;
        rsv_addr = ra;
        raddr    = {rd1, rd0};
        #2;
    endtask

    task automatic idle_read(input logic [4:0] rd0, input logic [4:0] rd1);
        apply_stimulus(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, rd0, rd1);
    endtask

    task automatic check_port(input string tag, input int k,
                              input logic [31:0] exp_d, input logic exp_b);
        check_output({tag, "_rdata"}, {32'h0, rdata[k*32 +: 32]}, {32'h0, exp_d});
        check_output({tag, "_rbusy"}, {63'h0, rbusy[k]}, {63'h0, exp_b});
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_port($sformatf("%s_p%0d", tag, k), k,
                       exp_read(raddr[k*5 +: 5]), exp_busy(raddr[k*5 +: 5]));
        end
    endtask

    task automatic clock_edge();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic clock_edge2();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence followed by randomized traffic and the second build.
    initial begin
        rst = 1'b1;
        we = '0; waddr = '0; wdata = '0; wstrb = '0; rsv_en = 1'b0; rsv_addr = '0;
        raddr = {5'd9, 5'd5};
        we2 = '0; waddr2 = '0; wdata2 = '0; wstrb2 = '0; rsv_en2 = 1'b0; rsv_addr2 = '0;
        raddr2 = '0;
        model_reset();
        #3;
        check_port("reset", 0, 32'h0, 1'b0);
        check_output("reset_dut2_rdata", rdata2[63:0], 64'h0);
        check_output("reset_dut2_rbusy", {61'h0, rbusy2}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Asynchronous reset in the middle of a cycle.
        apply_stimulus(2'b01, 5'd5, 32'hDEADBEEF, 4'hF, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        check_port("bypass_r5", 0, 32'hDEADBEEF, 1'b0);
        clock_edge();
        apply_stimulus(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5, 5'd5, 5'd5);
        check_port("rsv_same_cycle_r5", 0, 32'hDEADBEEF, 1'b0);
        clock_edge();
        idle_read(5'd5, 5'd5);
        check_port("busy_r5", 0, 32'hDEADBEEF, 1'b1);
        rst = 1'b1;
        #1;
        check_port("async_rst_p0", 0, 32'h0, 1'b0);
        check_port("async_rst_p1", 1, 32'h0, 1'b0);
        apply_stimulus(2'b01, 5'd5, 32'hFFFFFFFF, 4'hF, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        check_port("rst_hold_write", 0, 32'h0, 1'b0);
        model_reset();
        idle_read(5'd5, 5'd5);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_port("after_rst_r5", 0, 32'h0, 1'b0);

        // Basic write with same-cycle visibility.
        apply_stimulus(2'b01, 5'd3, 32'h12345678, 4'hF, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd3, 5'd3);
        check_port("basic_bypass", 0, 32'h12345678, 1'b0);
        clock_edge();
        idle_read(5'd3, 5'd0);
        check_port("basic_stored", 0, 32'h12345678, 1'b0);
        check_port("r0_idle", 1, 32'h0, 1'b0);

        // Per-byte merge, port 1 wins where both strobe.
        apply_stimulus(2'b01, 5'd7, 32'h11111111, 4'hF, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd7, 5'd7);
        clock_edge();
        apply_stimulus(2'b11, 5'd7, 32'hAAAAAAAA, 4'hF, 5'd7, 32'hBBBBBBBB, 4'h3, 1'b0, 5'd0, 5'd7, 5'd3);
        check_port("merge_bypass", 0, 32'hAAAABBBB, 1'b0);
        clock_edge();
        idle_read(5'd7, 5'd3);
        check_port("merge_stored", 0, 32'hAAAABBBB, 1'b0);
        check_port("merge_other_reg", 1, 32'h12345678, 1'b0);

        // Zero register ignores writes and reservations.
        apply_stimulus(2'b01, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 32'h0, 4'h0, 1'b1, 5'd0, 5'd0, 5'd0);
        check_port("zero_same_cycle", 0, 32'h0, 1'b0);
        clock_edge();
        idle_read(5'd0, 5'd0);
        check_port("zero_next_p0", 0, 32'h0, 1'b0);
        check_port("zero_next_p1", 1, 32'h0, 1'b0);

        // Scoreboard on r9.
        apply_stimulus(2'b01, 5'd9, 32'hCAFEF00D, 4'hF, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd9, 5'd9);
        clock_edge();
        apply_stimulus(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9, 5'd9, 5'd9);
        check_port("rsv_not_yet", 0, 32'hCAFEF00D, 1'b0);
        clock_edge();
        idle_read(5'd9, 5'd9);
        check_port("rsv_r9", 0, 32'hCAFEF00D, 1'b1);
        apply_stimulus(2'b10, 5'd0, 32'h0, 4'h0, 5'd9, 32'hFFFFFFFF, 4'h0, 1'b0, 5'd0, 5'd9, 5'd9);
        check_port("busy_drop_bypass", 0, 32'hCAFEF00D, 1'b0);
        clock_edge();
        idle_read(5'd9, 5'd9);
        check_port("busy_cleared_nostrb", 0, 32'hCAFEF00D, 1'b0);
        apply_stimulus(2'b01, 5'd9, 32'h01020304, 4'hF, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9, 5'd9, 5'd9);
        clock_edge();
        idle_read(5'd9, 5'd9);
        check_port("rsv_wins", 0, 32'h01020304, 1'b1);
        apply_stimulus(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9, 5'd9, 5'd9);
        clock_edge();
        idle_read(5'd9, 5'd9);
        check_port("rsv_again", 0, 32'h01020304, 1'b1);

        // Randomized traffic; small address window half the time to force
        // port collisions and read/write overlaps.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] lim;
            lim = ($urandom_range(0, 1) == 0) ? 5'd7 : 5'd31;
            apply_stimulus(2'($urandom),
                           5'($urandom_range(0, int'(lim))), $urandom, 4'($urandom),
                           5'($urandom_range(0, int'(lim))), $urandom, 4'($urandom),
                           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, int'(lim))),
                           5'($urandom_range(0, int'(lim))), 5'($urandom_range(0, int'(lim))));
            check_model($sformatf("rand%0d", n));
            clock_edge();
        end
        idle_read(5'd0, 5'd0);

        // Second build: no bypass, old value visible until the edge.
        we2 = 1'b1; waddr2 = 5'd0; wdata2 = 64'h0123456789ABCDEF; wstrb2 = 8'hFF;
        raddr2 = {5'd0, 5'd0, 5'd0};
        #2;
        check_output("d2_nobypass_old", rdata2[63:0], 64'h0);
        clock_edge2();
        we2 = 1'b0;
        #1;
        check_output("d2_r0_p0", rdata2[63:0], 64'h0123456789ABCDEF);
        check_output("d2_r0_p1", rdata2[127:64], 64'h0123456789ABCDEF);
        check_output("d2_r0_p2", rdata2[191:128], 64'h0123456789ABCDEF);
        check_output("d2_r0_busy", {61'h0, rbusy2}, 64'h0);

        // Out-of-range address 30: write and reservation dropped, reads 0.
        we2 = 1'b1; waddr2 = 5'd30; wdata2 = 64'hFFFFFFFFFFFFFFFF; wstrb2 = 8'hFF;
        rsv_en2 = 1'b1; rsv_addr2 = 5'd30;
        raddr2 = {5'd30, 5'd23, 5'd30};
        #2;
        check_output("d2_oor_rdata_now", rdata2[63:0], 64'h0);
        clock_edge2();
        we2 = 1'b0; rsv_en2 = 1'b0;
        #1;
        check_output("d2_oor_rdata", rdata2[63:0], 64'h0);
        check_output("d2_oor_rdata_p2", rdata2[191:128], 64'h0);
        check_output("d2_oor_rbusy", {61'h0, rbusy2}, 64'h0);
        check_output("d2_r23_untouched", rdata2[127:64], 64'h0);

        // Last valid register, low four byte lanes only.
        we2 = 1'b1; waddr2 = 5'd23; wdata2 = 64'hFEEDFACE12345678; wstrb2 = 8'h0F;
        clock_edge2();
        we2 = 1'b0;
        #1;
        check_output("d2_r23_partial", rdata2[127:64], 64'h0000000012345678);

        // Register 0 is ordinary here: it can be reserved, and without
        // bypass the flag holds through the write cycle.
        raddr2 = {5'd23, 5'd0, 5'd0};
        rsv_en2 = 1'b1; rsv_addr2 = 5'd0;
        clock_edge2();
        rsv_en2 = 1'b0;
        #1;
        check_output("d2_r0_reserved", {63'h0, rbusy2[0]}, 64'h1);
        we2 = 1'b1; waddr2 = 5'd0; wdata2 = 64'h0; wstrb2 = 8'h00;
        #1;
        check_output("d2_busy_hold_nobypass", {63'h0, rbusy2[0]}, 64'h1);
        clock_edge2();
        we2 = 1'b0;
        #1;
        check_output("d2_busy_cleared", {61'h0, rbusy2}, 64'h0);
        check_output("d2_r0_kept", rdata2[63:0], 64'h0123456789ABCDEF);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
